delay_tap_calibrator: RTL

Sweep controller that sits directly upstream of the cascaded input delay pair and drives its delay_load / delay__value load interface. On request it steps the tap value from 0 to MAX_TAP and scores each tap with a per-cycle pattern-match flag from the downstream checker. It then finds the longest contiguous run of good taps and loads the centre tap. It reports the final eye start, eye width and pass/fail to software.

---
 rtl/delay_tap_calibrator.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/delay_tap_calibrator.sv
// delay_tap_calibrator: sweeps delay taps 0..MAX_TAP, scores each tap, loads the centre of the longest good run.
// Define DELAY_CAL_ERR_TOL_EN to accept taps with up to ERR_TOL errors instead of zero.
module delay_tap_calibrator #(
  parameter int MAX_TAP = 511,
  parameter int SETTLE_CYCLES = 8,
  parameter int WINDOW_CYCLES = 64
`ifdef DELAY_CAL_ERR_TOL_EN
  , parameter int ERR_TOL = 1
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       sample_valid,
  input  logic       sample_ok,
  output logic       delay_load,
  output logic [8:0] delay__value,
  output logic       busy,
  output logic       done,
  output logic       locked,
  output logic [8:0] eye_start,
  output logic [9:0] eye_width
);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SAMPLE, EVAL, CENTER, CENTER_SETTLE, FINISH} state_e;
  localparam logic [8:0] LAST = 9'(MAX_TAP);
  localparam logic [15:0] SET_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] WIN_LAST = 16'(WINDOW_CYCLES - 1);
  state_e state_q, state_d;
  logic [8:0] tap_q, tap_d, val_q, val_d, cur_start_q, cur_start_d, best_start_q, best_start_d, eye_start_q, eye_start_d;
  logic [9:0] cur_len_q, cur_len_d, best_len_q, best_len_d, eye_width_q, eye_width_d, centre;
  logic [15:0] cnt_q, cnt_d, err_q, err_d;
  logic locked_q, locked_d, good;
`ifdef DELAY_CAL_ERR_TOL_EN
  assign good = err_q <= 16'(ERR_TOL);
`else
  assign good = err_q == 16'd0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tap_q <= '0;
      val_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
      cur_start_q <= '0;
      cur_len_q <= '0;
      best_start_q <= '0;
      best_len_q <= '0;
      locked_q <= 1'b0;
      eye_start_q <= '0;
      eye_width_q <= '0;
    end else begin
      state_q <= state_d;
      tap_q <= tap_d;
      val_q <= val_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      cur_start_q <= cur_start_d;
      cur_len_q <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q <= best_len_d;
      locked_q <= locked_d;
      eye_start_q <= eye_start_d;
      eye_width_q <= eye_width_d;
    end
  end
  always_comb begin
    state_d = state_q;
    tap_d = tap_q;
    val_d = val_q;
    cnt_d = cnt_q;
    err_d = err_q;
    cur_start_d = cur_start_q;
    cur_len_d = cur_len_q;
    best_start_d = best_start_q;
    best_len_d = best_len_q;
    locked_d = locked_q;
    eye_start_d = eye_start_q;
    eye_width_d = eye_width_q;
    centre = '0;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        tap_d = '0;
        val_d = '0;
        cur_start_d = '0;
        cur_len_d = '0;
        best_start_d = '0;
        best_len_d = '0;
        locked_d = 1'b0;
        eye_start_d = '0;
        eye_width_d = '0;
      end
      LOAD: begin
        state_d = SETTLE;
        cnt_d = '0;
        err_d = '0;
      end
      SETTLE: begin
        state_d = cnt_q == SET_LAST ? SAMPLE : SETTLE;
        cnt_d = cnt_q == SET_LAST ? 16'd0 : cnt_q + 16'd1;
      end
      SAMPLE: if (sample_valid) begin
        err_d = (!sample_ok && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
        state_d = cnt_q == WIN_LAST ? EVAL : SAMPLE;
        cnt_d = cnt_q + 16'd1;
      end
      EVAL: begin
        cur_len_d = good ? cur_len_q + 10'd1 : 10'd0;
        cur_start_d = (good && cur_len_q == 10'd0) ? tap_q : cur_start_q;
        best_len_d = cur_len_d > best_len_q ? cur_len_d : best_len_q;
        best_start_d = cur_len_d > best_len_q ? cur_start_d : best_start_q;
        centre = {1'b0, best_start_d} + ((best_len_d - 10'd1) >> 1);
        // The value register is loaded on entry so it is already stable when delay_load rises.
        state_d = tap_q == LAST ? CENTER : LOAD;
        locked_d = tap_q == LAST ? best_len_d != 10'd0 : locked_q;
        val_d = tap_q != LAST ? tap_q + 9'd1 : best_len_d != 10'd0 ? centre[8:0] : 9'd0;
        tap_d = val_d;
      end
      CENTER: begin
        state_d = CENTER_SETTLE;
        cnt_d = '0;
      end
      CENTER_SETTLE: begin
        state_d = cnt_q == SET_LAST ? FINISH : CENTER_SETTLE;
        cnt_d = cnt_q + 16'd1;
      end
      FINISH: begin
        state_d = IDLE;
        eye_start_d = best_start_q;
        eye_width_d = best_len_q;
      end
      default: state_d = IDLE;
    endcase
  end
  assign delay_load = state_q == LOAD || state_q == CENTER;
  assign delay__value = val_q;
  assign busy = state_q != IDLE;
  assign done = state_q == FINISH;
  assign locked = locked_q;
  assign eye_start = eye_start_q;
  assign eye_width = eye_width_q;
endmodule
